// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the Data_Memory arbiter:
//                FSM state encoding, requester port id, alignment mask.
//  Revision    : 1.0 - initial release
// ============================================================================
package dmem_arb_pkg;

   // Access sequencing: accept in IDLE, strobe memory in ACCESS, respond in RESP
   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   // Requester identity: port 0 is the MEM stage, port 1 the loader/debug port
   typedef enum logic {
      PORT0 = 1'b0,
      PORT1 = 1'b1
   } port_id_t;

   // Low address bits that must be zero for a 64-bit word access
   localparam logic [2:0] ALIGN_MASK = 3'b111;

   function automatic logic is_aligned(input logic [2:0] lsbs);
      return (lsbs & ALIGN_MASK) == 3'b000;
   endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_arb_if.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_if
//  Description : Bundle of the two requester ports, shared response signals
//                and the Data_Memory strobe/address/data lines.
//                slave  = arbiter side, master = requesters + memory side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dmem_arb_if #(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
);
   logic              p0_req_valid;
   logic              p0_req_we;
   logic [ADDR_W-1:0] p0_req_addr;
   logic [DATA_W-1:0] p0_req_wdata;
   logic              p0_req_ready;

   logic              p1_req_valid;
   logic              p1_req_we;
   logic [ADDR_W-1:0] p1_req_addr;
   logic [DATA_W-1:0] p1_req_wdata;
   logic              p1_req_ready;

   logic              p0_rsp_valid;
   logic              p1_rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   logic              mem_read;
   logic              mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   modport slave (
      input  p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
      input  p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
      input  mem_rdata,
      output p0_req_ready, p1_req_ready,
      output p0_rsp_valid, p1_rsp_valid, rsp_rdata, rsp_err,
      output mem_read, mem_write, mem_addr, mem_wdata
   );

   modport master (
      output p0_req_valid, p0_req_we, p0_req_addr, p0_req_wdata,
      output p1_req_valid, p1_req_we, p1_req_addr, p1_req_wdata,
      output mem_rdata,
      input  p0_req_ready, p1_req_ready,
      input  p0_rsp_valid, p1_rsp_valid, rsp_rdata, rsp_err,
      input  mem_read, mem_write, mem_addr, mem_wdata
   );

endinterface
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port arbiter in front of Data_Memory. One access every
//                three cycles: accept (IDLE), memory strobe (ACCESS),
//                completion pulse (RESP). Misaligned accesses never reach
//                memory and complete with rsp_err set.
//  Config      : DMEM_ARB_ROUND_ROBIN_EN defined -> round-robin on ties,
//                undefined -> fixed priority, port 0 wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W = 64,
   parameter int DATA_W = 64
) (
   input  wire logic  clk,
   input  wire logic  reset,
   dmem_arb_if.slave  bus
);

   state_t            state;
   port_id_t          owner;
   port_id_t          grant;
   logic              cmd_err;
   logic              rd_stb;
   logic              wr_stb;
   logic [ADDR_W-1:0] addr_hold;
   logic [DATA_W-1:0] wdata_hold;
   logic              rsp0;
   logic              rsp1;
   logic [DATA_W-1:0] rdata_out;
   logic              err_out;
   logic              accept;
   logic              sel_we;
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_wdata;
   logic              sel_aligned;

`ifdef DMEM_ARB_ROUND_ROBIN_EN
   port_id_t          last_grant;
`endif

   // Pick the port that would win if a request were accepted this cycle
   always_comb begin
      grant = PORT0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
      if (bus.p0_req_valid && bus.p1_req_valid)
         grant = (last_grant == PORT0) ? PORT1 : PORT0;
      else if (bus.p1_req_valid)
         grant = PORT1;
`else
      if (!bus.p0_req_valid && bus.p1_req_valid)
         grant = PORT1;
`endif
   end

   // Ready only for the granted, valid port while idle and out of reset
   assign bus.p0_req_ready = !reset && (state == IDLE) && (grant == PORT0) && bus.p0_req_valid;
   assign bus.p1_req_ready = !reset && (state == IDLE) && (grant == PORT1) && bus.p1_req_valid;
   assign accept           = bus.p0_req_ready || bus.p1_req_ready;

   assign sel_we      = (grant == PORT1) ? bus.p1_req_we    : bus.p0_req_we;
   assign sel_addr    = (grant == PORT1) ? bus.p1_req_addr  : bus.p0_req_addr;
   assign sel_wdata   = (grant == PORT1) ? bus.p1_req_wdata : bus.p0_req_wdata;
   assign sel_aligned = is_aligned(sel_addr[2:0]);

   // Access FSM with registered memory strobes and response outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= PORT0;
         cmd_err    <= 1'b0;
         rd_stb     <= 1'b0;
         wr_stb     <= 1'b0;
         addr_hold  <= '0;
         wdata_hold <= '0;
         rsp0       <= 1'b0;
         rsp1       <= 1'b0;
         rdata_out  <= '0;
         err_out    <= 1'b0;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
         last_grant <= PORT1;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  state      <= ACCESS;
                  owner      <= grant;
                  addr_hold  <= sel_addr;
                  wdata_hold <= sel_wdata;
                  cmd_err    <= !sel_aligned;
                  // Misaligned commands skip the memory strobe entirely
                  rd_stb     <= !sel_we && sel_aligned;
                  wr_stb     <= sel_we && sel_aligned;
`ifdef DMEM_ARB_ROUND_ROBIN_EN
                  last_grant <= grant;
`endif
               end
            end
            ACCESS: begin
               state     <= RESP;
               rd_stb    <= 1'b0;
               wr_stb    <= 1'b0;
               rsp0      <= (owner == PORT0);
               rsp1      <= (owner == PORT1);
               err_out   <= cmd_err;
               // Read data is only meaningful while the read strobe is high
               rdata_out <= rd_stb ? bus.mem_rdata : '0;
            end
            RESP: begin
               state     <= IDLE;
               rsp0      <= 1'b0;
               rsp1      <= 1'b0;
               err_out   <= 1'b0;
               rdata_out <= '0;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.mem_read     = rd_stb;
   assign bus.mem_write    = wr_stb;
   assign bus.mem_addr     = addr_hold;
   assign bus.mem_wdata    = wdata_hold;
   assign bus.p0_rsp_valid = rsp0;
   assign bus.p1_rsp_valid = rsp1;
   assign bus.rsp_rdata    = rdata_out;
   assign bus.rsp_err      = err_out;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. Directed requests push
//                expected responses into a scoreboard; a negedge monitor pops
//                and compares them when a response pulse appears.
//  Config      : honours DMEM_ARB_ROUND_ROBIN_EN for the tie-break check.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

   localparam int AW = 64;
   localparam int DW = 64;

   typedef struct {
      logic          port;
      logic [DW-1:0] rdata;
      logic          err;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total    = 0;
   int   pass_cnt = 0;
   exp_t sb[$];
   exp_t mon_e;
   logic [DW-1:0] ref_mem [0:31];

   // Data_Memory model: word array, written on mem_write, read combinationally
   logic [DW-1:0] dmem [0:31] = '{2: 64'hDEAD, default: 64'h0};

   always #5 clk = ~clk;

   dmem_arb_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

   dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always @(posedge clk) begin
      if (bus.mem_write) dmem[bus.mem_addr[7:3]] <= bus.mem_wdata;
   end
   assign bus.mem_rdata = dmem[bus.mem_addr[7:3]];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Response monitor: every pulse must match the oldest outstanding request
   always @(negedge clk) begin
      check("strobe_excl", bus.mem_read & bus.mem_write, 0);
      if (bus.p0_rsp_valid || bus.p1_rsp_valid) begin
         check("rsp_onehot", bus.p0_rsp_valid & bus.p1_rsp_valid, 0);
         check("sb_nonempty", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            check("rsp_port", bus.p1_rsp_valid, mon_e.port);
            check("rsp_rdata", bus.rsp_rdata, mon_e.rdata);
            check("rsp_err", bus.rsp_err, mon_e.err);
         end
      end else begin
         check("idle_rdata", bus.rsp_rdata, 0);
         check("idle_err", bus.rsp_err, 0);
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic drive(input logic port, input logic v, input logic we,
                        input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
      if (port == 1'b0) begin
         bus.p0_req_valid = v; bus.p0_req_we = we;
         bus.p0_req_addr  = addr; bus.p0_req_wdata = wdata;
      end else begin
         bus.p1_req_valid = v; bus.p1_req_we = we;
         bus.p1_req_addr  = addr; bus.p1_req_wdata = wdata;
      end
   endtask

   // Issue one request starting just after a negedge; returns at negedge N+2
   task automatic req(input logic port, input logic we, input logic [AW-1:0] addr,
                      input logic [DW-1:0] wdata, output int waited);
      exp_t e;
      logic aligned;
      logic rdy;
      aligned = (addr[2:0] == 3'b000);
      e.port  = port;
      e.err   = !aligned;
      e.rdata = (!we && aligned) ? ref_mem[addr[7:3]] : 64'h0;
      if (we && aligned) ref_mem[addr[7:3]] = wdata;
      drive(port, 1'b1, we, addr, wdata);
      waited = 0;
      #1;
      rdy = port ? bus.p1_req_ready : bus.p0_req_ready;
      while (!rdy && waited < 20) begin
         @(negedge clk); #1;
         waited++;
         rdy = port ? bus.p1_req_ready : bus.p0_req_ready;
      end
      check("accept", rdy, 1);
      check("other_ready", port ? bus.p0_req_ready : bus.p1_req_ready, 0);
      sb.push_back(e);
      @(negedge clk);
      drive(port, 1'b0, 1'b0, '0, '0);
      #1;
      check("access_read", bus.mem_read, !we && aligned);
      check("access_write", bus.mem_write, we && aligned);
      if (aligned) check("access_addr", bus.mem_addr, addr);
      if (we && aligned) check("access_wdata", bus.mem_wdata, wdata);
      @(negedge clk);
      #1;
      check("resp_strobes", {bus.mem_read, bus.mem_write}, 0);
   endtask

   initial begin
      int w;
      int gcnt;
      logic exp_port;
      for (int i = 0; i < 32; i++) ref_mem[i] = 64'h0;
      ref_mem[2] = 64'hDEAD;
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      repeat (3) @(negedge clk);
      #1;
      check("rst_ready0", bus.p0_req_ready, 0);
      check("rst_ready1", bus.p1_req_ready, 0);
      check("rst_mem_read", bus.mem_read, 0);
      check("rst_mem_write", bus.mem_write, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_rsp", {bus.p0_rsp_valid, bus.p1_rsp_valid}, 0);
      check("rst_rdata", bus.rsp_rdata, 0);
      check("rst_err", bus.rsp_err, 0);
      @(negedge clk);
      reset = 1'b0;

      // Basic load, store, readback, misaligned accesses
      @(negedge clk); req(1'b0, 1'b0, 64'h10, 64'h0, w);
      check("first_wait", w, 0);
      @(negedge clk); req(1'b1, 1'b1, 64'h20, 64'h55, w);
      check("back_to_back_wait", w, 0);
      @(negedge clk); req(1'b0, 1'b0, 64'h20, 64'h0, w);
      @(negedge clk); req(1'b0, 1'b0, 64'h13, 64'h0, w);
      @(negedge clk); req(1'b1, 1'b1, 64'h21, 64'hBAD, w);
      @(negedge clk); req(1'b1, 1'b0, 64'h20, 64'h0, w);
      @(negedge clk); req(1'b0, 1'b1, 64'h38, 64'h1234_5678_9ABC_DEF0, w);
      @(negedge clk); req(1'b1, 1'b0, 64'h38, 64'h0, w);

      // Reset during ACCESS aborts the access
      @(negedge clk);
      drive(1'b0, 1'b1, 1'b0, 64'h10, '0);
      #1;
      check("abort_accept", bus.p0_req_ready, 1);
      @(negedge clk);
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      #1;
      check("abort_access_read", bus.mem_read, 1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      check("abort_strobes", {bus.mem_read, bus.mem_write}, 0);
      check("abort_no_rsp", {bus.p0_rsp_valid, bus.p1_rsp_valid}, 0);
      reset = 1'b0;
      req(1'b0, 1'b0, 64'h10, 64'h0, w);
      check("post_reset_wait", w, 0);

      // Continuous contention from both ports after a fresh reset
      @(negedge clk);
      reset = 1'b1;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      drive(1'b0, 1'b1, 1'b0, 64'h10, '0);
      drive(1'b1, 1'b1, 1'b0, 64'h20, '0);
      gcnt = 0;
      for (int k = 0; k < 12; k++) begin
         #1;
         check("one_ready", bus.p0_req_ready & bus.p1_req_ready, 0);
         if (bus.p0_req_ready || bus.p1_req_ready) begin
`ifdef DMEM_ARB_ROUND_ROBIN_EN
            exp_port = gcnt[0];
`else
            exp_port = 1'b0;
`endif
            check("grant_cycle", k, gcnt * 3);
            check("grant_port", bus.p1_req_ready, exp_port);
            sb.push_back('{port: bus.p1_req_ready,
                           rdata: bus.p1_req_ready ? ref_mem[4] : ref_mem[2],
                           err: 1'b0});
            gcnt++;
         end
         @(negedge clk);
      end
      drive(1'b0, 1'b0, 1'b0, '0, '0);
      drive(1'b1, 1'b0, 1'b0, '0, '0);
      check("grant_count", gcnt, 4);

      repeat (4) @(negedge clk);
      #1;
      check("sb_drained", sb.size(), 0);
      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
`default_nettype wire
